// File: rtl/mm_seq_pkg.sv
// -----------------------------------------------------------------------------
// mm_seq_pkg
// Shared types and constants for the multiple_modules vector sequencer.
//   seq_state_e : sequencer FSM state encoding
//   VEC_W       : width of the vector index {a,b,c}
//   NUM_VEC     : number of input vectors swept
//   ERR_W       : width of the mismatch counter (holds 0..8)
//   MM_TRUTH    : expected y per vector index, (a&b)|c
// -----------------------------------------------------------------------------
package mm_seq_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;
    localparam int ERR_W   = 4;

    localparam logic [7:0] MM_TRUTH = 8'hEA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    // Expected datapath output for a given vector index under a truth table.
    function automatic logic expected_y(input logic [7:0] truth, input logic [VEC_W-1:0] vec);
        return truth[vec];
    endfunction

endpackage

// File: rtl/mm_settle_timer.sv
// -----------------------------------------------------------------------------
// mm_settle_timer
// 4-bit settle counter with clear and enable; tc flags the last settle cycle.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   clr   in  force count to zero (wins over en)
//   en    in  advance count by one
//   tc    out high while count == SETTLE_CYC-1
// -----------------------------------------------------------------------------
module mm_settle_timer #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [3:0] cnt_r;

    // Settle cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (clr) begin
            cnt_r <= 4'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == 4'(SETTLE_CYC - 32'd1));

endmodule

// File: rtl/mm_vector_sequencer.sv
// -----------------------------------------------------------------------------
// mm_vector_sequencer
// Sweeps the multiple_modules datapath through all 8 {a,b,c} vectors, holds
// each for SETTLE_CYC cycles, samples y_in and compares it with TRUTH.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, abort    begin a sweep (IDLE only) / terminate a sweep
//   y_in            datapath output
//   a, b, c         registered datapath drives (vec[2], vec[1], vec[0])
//   busy            high in SETTLE/SAMPLE/DONE
//   done            one-cycle completion pulse
//   pass            last completed sweep had no mismatches
//   err_cnt         mismatch count of current/last sweep
//   fail_map        bit i set when vector i mismatched
//   first_fail_vld, first_fail_vec  first mismatch of the sweep
//                   (present only when MM_SEQ_FIRSTFAIL_EN is defined)
// -----------------------------------------------------------------------------
module mm_vector_sequencer
    import mm_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [7:0]  TRUTH      = MM_TRUTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             y_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       fail_map
`ifdef MM_SEQ_FIRSTFAIL_EN
    ,
    output logic             first_fail_vld,
    output logic [VEC_W-1:0] first_fail_vec
`endif
);

    seq_state_e       state_r,    state_nxt_s;
    logic [VEC_W-1:0] vec_r,      vec_nxt_s;
    logic [VEC_W-1:0] abc_r,      abc_nxt_s;
    logic [ERR_W-1:0] err_cnt_r,  err_cnt_nxt_s;
    logic [7:0]       fail_map_r, fail_map_nxt_s;
    logic             pass_r,     pass_nxt_s;
    logic             done_r,     done_nxt_s;
    logic             busy_r;
    logic             tc_s;
    logic             mismatch_s;
    logic             ff_vld_r,   ff_vld_nxt_s;
    logic [VEC_W-1:0] ff_vec_r,   ff_vec_nxt_s;

    // The counter only runs while settling, so it is zero on every entry to SETTLE.
    mm_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_r != ST_SETTLE),
        .en    (state_r == ST_SETTLE),
        .tc    (tc_s)
    );

    assign mismatch_s = (y_in != expected_y(TRUTH, vec_r));

    // Next-state and next-result computation.
    always_comb begin
        state_nxt_s    = state_r;
        vec_nxt_s      = vec_r;
        abc_nxt_s      = abc_r;
        err_cnt_nxt_s  = err_cnt_r;
        fail_map_nxt_s = fail_map_r;
        pass_nxt_s     = pass_r;
        done_nxt_s     = 1'b0;
        ff_vld_nxt_s   = ff_vld_r;
        ff_vec_nxt_s   = ff_vec_r;

        if ((state_r != ST_IDLE) && abort) begin
            // Partial err_cnt/fail_map and first-fail are deliberately kept.
            state_nxt_s = ST_IDLE;
            abc_nxt_s   = {VEC_W{1'b0}};
            pass_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_nxt_s    = ST_SETTLE;
                        vec_nxt_s      = {VEC_W{1'b0}};
                        abc_nxt_s      = {VEC_W{1'b0}};
                        err_cnt_nxt_s  = {ERR_W{1'b0}};
                        fail_map_nxt_s = 8'h00;
                        pass_nxt_s     = 1'b0;
                        ff_vld_nxt_s   = 1'b0;
                        ff_vec_nxt_s   = {VEC_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (tc_s) begin
                        state_nxt_s = ST_SAMPLE;
                    end else begin
                        state_nxt_s = ST_SETTLE;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch_s) begin
                        fail_map_nxt_s[vec_r] = 1'b1;
                        err_cnt_nxt_s         = err_cnt_r + 4'd1;
                        if (!ff_vld_r) begin
                            ff_vld_nxt_s = 1'b1;
                            ff_vec_nxt_s = vec_r;
                        end else begin
                            ff_vld_nxt_s = ff_vld_r;
                        end
                    end else begin
                        err_cnt_nxt_s = err_cnt_r;
                    end
                    // vec never wraps: the last vector leaves for DONE.
                    if (vec_r == VEC_W'(NUM_VEC - 1)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        vec_nxt_s   = vec_r + 3'd1;
                        abc_nxt_s   = vec_r + 3'd1;
                        state_nxt_s = ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_nxt_s  = 1'b1;
                    pass_nxt_s  = (err_cnt_r == 4'd0);
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    abc_nxt_s   = {VEC_W{1'b0}};
                    pass_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            vec_r      <= {VEC_W{1'b0}};
            abc_r      <= {VEC_W{1'b0}};
            err_cnt_r  <= {ERR_W{1'b0}};
            fail_map_r <= 8'h00;
            pass_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            ff_vld_r   <= 1'b0;
            ff_vec_r   <= {VEC_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            vec_r      <= vec_nxt_s;
            abc_r      <= abc_nxt_s;
            err_cnt_r  <= err_cnt_nxt_s;
            fail_map_r <= fail_map_nxt_s;
            pass_r     <= pass_nxt_s;
            done_r     <= done_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            ff_vld_r   <= ff_vld_nxt_s;
            ff_vec_r   <= ff_vec_nxt_s;
        end
    end

    assign a        = abc_r[2];
    assign b        = abc_r[1];
    assign c        = abc_r[0];
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_cnt_r;
    assign fail_map = fail_map_r;

`ifdef MM_SEQ_FIRSTFAIL_EN
    assign first_fail_vld = ff_vld_r;
    assign first_fail_vec = ff_vec_r;
`endif

endmodule

// File: tb/tb_mm_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mm_vector_sequencer
// Scoreboard bench for mm_vector_sequencer. y_in comes from a behavioural
// (a&b)|c datapath, or is forced to 0 or 1. Expected sweep results are pushed
// when a sweep is started and popped when done pulses.
// Optional: define MM_SEQ_FIRSTFAIL_EN to cover the first-fail ports.
// -----------------------------------------------------------------------------
module tb_mm_vector_sequencer;

    localparam logic [7:0] TRUTH_EXP = 8'hEA;
    localparam int         LAT_EXP   = 25;

    typedef struct {
        logic [3:0] err;
        logic [7:0] map;
        logic       pass;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    int         mode;
    logic       y_in;
    logic       a, b, c, busy, done, pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_map;
`ifdef MM_SEQ_FIRSTFAIL_EN
    logic       first_fail_vld;
    logic [2:0] first_fail_vec;
`endif

    always #5 clk = ~clk;

    // mode 0: real multiple_modules function, 1: stuck-at-0, 2: stuck-at-1
    assign y_in = (mode == 0) ? ((a & b) | c) : ((mode == 1) ? 1'b0 : 1'b1);

    mm_vector_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .y_in     (y_in),
        .a        (a),
        .b        (b),
        .c        (c),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_map (fail_map)
`ifdef MM_SEQ_FIRSTFAIL_EN
        ,
        .first_fail_vld (first_fail_vld),
        .first_fail_vec (first_fail_vec)
`endif
    );

    function automatic exp_t model_sweep(input int m);
        exp_t       e;
        logic [2:0] vv;
        logic       yv;
        e.err = 4'd0;
        e.map = 8'h00;
        for (int v = 0; v < 8; v++) begin
            vv = 3'(v);
            yv = (m == 0) ? ((vv[2] & vv[1]) | vv[0]) : ((m == 1) ? 1'b0 : 1'b1);
            if (yv != TRUTH_EXP[v]) begin
                e.map[v] = 1'b1;
                e.err    = e.err + 4'd1;
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and wait for done; lat = cycles from accept edge, -1 on timeout.
    task automatic start_and_wait(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (done === 1'b1) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
        tick(); tick();
        checks++; if ({a, b, c} !== 3'b000) begin failures++; $display("FAIL reset_abc actual=%b expected=000", {a, b, c}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass actual=%b expected=0", pass); end
        checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL reset_err actual=%0d expected=0", err_cnt); end
        checks++; if (fail_map !== 8'h00) begin failures++; $display("FAIL reset_map actual=%h expected=00", fail_map); end
`ifdef MM_SEQ_FIRSTFAIL_EN
        checks++; if (first_fail_vld !== 1'b0) begin failures++; $display("FAIL reset_ffvld actual=%b expected=0", first_fail_vld); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_real_datapath();
        exp_t e;
        int   lat;
        mode = 0;
        sb_q.push_back(model_sweep(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int j = 0; j <= 40; j++) begin
            if (j > 0) tick();
            if (j <= 23) begin
                checks++;
                if ({a, b, c} !== 3'(j / 3)) begin
                    failures++;
                    $display("FAIL abc_cycle%0d actual=%0d expected=%0d", j, {a, b, c}, j / 3);
                end
            end
            if (done === 1'b1) begin
                lat = j;
                break;
            end
        end
        checks++; if (lat !== LAT_EXP) begin failures++; $display("FAIL real_latency actual=%0d expected=%0d", lat, LAT_EXP); end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++; if (err_cnt !== e.err) begin failures++; $display("FAIL real_err actual=%0d expected=%0d", err_cnt, e.err); end
            checks++; if (fail_map !== e.map) begin failures++; $display("FAIL real_map actual=%h expected=%h", fail_map, e.map); end
            checks++; if (pass !== e.pass) begin failures++; $display("FAIL real_pass actual=%b expected=%b", pass, e.pass); end
        end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle actual=%b expected=0", done); end
    endtask

    task automatic test_forced_zero();
        exp_t e;
        int   lat;
        mode = 1;
        sb_q.push_back(model_sweep(1));
        start_and_wait(lat);
        checks++; if (lat !== LAT_EXP) begin failures++; $display("FAIL zero_latency actual=%0d expected=%0d", lat, LAT_EXP); end
        e = sb_q.pop_front();
        checks++; if (err_cnt !== e.err) begin failures++; $display("FAIL zero_err actual=%0d expected=%0d", err_cnt, e.err); end
        checks++; if (fail_map !== e.map) begin failures++; $display("FAIL zero_map actual=%h expected=%h", fail_map, e.map); end
        checks++; if (pass !== e.pass) begin failures++; $display("FAIL zero_pass actual=%b expected=%b", pass, e.pass); end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;                       // mid-sweep start, must be ignored
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midstart_busy actual=%b expected=1", busy); end
        checks++; if ({a, b, c} !== 3'd1) begin failures++; $display("FAIL midstart_abc actual=%0d expected=1", {a, b, c}); end
        repeat (4) tick();
        checks++; if ({a, b, c} !== 3'd3) begin failures++; $display("FAIL vec3_abc actual=%0d expected=3", {a, b, c}); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy actual=%b expected=0", busy); end
        checks++; if ({a, b, c} !== 3'b000) begin failures++; $display("FAIL abort_abc actual=%b expected=000", {a, b, c}); end
        checks++; if (fail_map !== 8'h02) begin failures++; $display("FAIL abort_map actual=%h expected=02", fail_map); end
        checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL abort_err actual=%0d expected=1", err_cnt); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL abort_pass actual=%b expected=0", pass); end
        seen = 0;
        for (int j = 0; j < 30; j++) begin
            if (done === 1'b1) seen = 1;
            tick();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done actual=%0d expected=0", seen); end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_abort_busy actual=%b expected=0", busy); end
        tick();
        checks++; if (fail_map !== 8'h02) begin failures++; $display("FAIL start_abort_map actual=%h expected=02", fail_map); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL idle_abort_err actual=%0d expected=1", err_cnt); end
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        int   lat;
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        start = 1'b1; abort = 1'b1;         // reset dominates both
        tick();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy actual=%b expected=0", busy); end
        checks++; if ({a, b, c} !== 3'b000) begin failures++; $display("FAIL midrst_abc actual=%b expected=000", {a, b, c}); end
        checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL midrst_err actual=%0d expected=0", err_cnt); end
        checks++; if (fail_map !== 8'h00) begin failures++; $display("FAIL midrst_map actual=%h expected=00", fail_map); end
        rst_n = 1'b1;
        tick();
        mode = 0;
        sb_q.push_back(model_sweep(0));
        start_and_wait(lat);
        checks++; if (lat !== LAT_EXP) begin failures++; $display("FAIL postrst_latency actual=%0d expected=%0d", lat, LAT_EXP); end
        e = sb_q.pop_front();
        checks++; if (pass !== e.pass) begin failures++; $display("FAIL postrst_pass actual=%b expected=%b", pass, e.pass); end
        checks++; if (fail_map !== e.map) begin failures++; $display("FAIL postrst_map actual=%h expected=%h", fail_map, e.map); end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        mode = 1;
        sb_q.push_back(model_sweep(1));
        start_and_wait(lat);
        e = sb_q.pop_front();
        checks++; if (err_cnt !== e.err) begin failures++; $display("FAIL b2b1_err actual=%0d expected=%0d", err_cnt, e.err); end
        mode = 0;
        sb_q.push_back(model_sweep(0));
        start_and_wait(lat);
        checks++; if (lat !== LAT_EXP) begin failures++; $display("FAIL b2b2_latency actual=%0d expected=%0d", lat, LAT_EXP); end
        e = sb_q.pop_front();
        checks++; if (err_cnt !== e.err) begin failures++; $display("FAIL b2b2_err actual=%0d expected=%0d", err_cnt, e.err); end
        checks++; if (pass !== e.pass) begin failures++; $display("FAIL b2b2_pass actual=%b expected=%b", pass, e.pass); end
        tick();
    endtask

`ifdef MM_SEQ_FIRSTFAIL_EN
    task automatic test_first_fail();
        exp_t e;
        int   lat;
        mode = 2;
        sb_q.push_back(model_sweep(2));
        start_and_wait(lat);
        e = sb_q.pop_front();
        checks++; if (err_cnt !== e.err) begin failures++; $display("FAIL ff_err actual=%0d expected=%0d", err_cnt, e.err); end
        checks++; if (fail_map !== e.map) begin failures++; $display("FAIL ff_map actual=%h expected=%h", fail_map, e.map); end
        checks++; if (first_fail_vld !== 1'b1) begin failures++; $display("FAIL ff_vld actual=%b expected=1", first_fail_vld); end
        checks++; if (first_fail_vec !== 3'd0) begin failures++; $display("FAIL ff_vec actual=%0d expected=0", first_fail_vec); end
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
        test_reset();
        test_real_datapath();
        test_forced_zero();
        test_abort();
        test_reset_mid_sweep();
        test_back_to_back();
`ifdef MM_SEQ_FIRSTFAIL_EN
        test_first_fail();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
